uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync2.sv | 25 ++
 rtl/uart_rx.sv | 143 ++++++++++++++
 tb/tb_uart_rx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding, frame width and
// default line timing shared with the transmitter.
package uart_pkg;

  localparam int unsigned DATA_BITS     = 8;
  localparam int unsigned CLK_FREQ_DFLT = 50_000_000;
  localparam int unsigned BAUD_DFLT     = 9600;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input. Both flops
// reset high so an idle-high line does not look like a start bit.
module uart_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: samples each bit at mid-period, reports good bytes with
// a one-cycle valid pulse and bad stop bits with a one-cycle frame_err pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = CLK_FREQ_DFLT,
  parameter int unsigned BAUD         = BAUD_DFLT,
  parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic                 clk_50M,
  input  logic                 reset,
  input  logic                 uart_rxd,
  output logic [DATA_BITS-1:0] outdata,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] LP_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LP_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LP_LAST = IDX_W'(DATA_BITS - 1);

  uart_state_e          r_state;
  uart_state_e          w_state_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_next;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [IDX_W-1:0]     w_bit_idx_next;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_next;
  logic [DATA_BITS-1:0] r_outdata;
  logic [DATA_BITS-1:0] w_outdata_next;
  logic                 r_valid;
  logic                 w_valid_next;
  logic                 r_frame_err;
  logic                 w_frame_err_next;
  logic                 r_busy;
  logic                 w_busy_next;
  logic                 r_wait_high;
  logic                 w_wait_high_next;
  logic                 w_rxd_s;

  uart_sync2 u_sync (
    .i_clk (clk_50M),
    .i_rst (reset),
    .i_d   (uart_rxd),
    .o_q   (w_rxd_s)
  );

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_outdata   <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
      r_wait_high <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_bit_idx   <= w_bit_idx_next;
      r_shift     <= w_shift_next;
      r_outdata   <= w_outdata_next;
      r_valid     <= w_valid_next;
      r_frame_err <= w_frame_err_next;
      r_busy      <= w_busy_next;
      r_wait_high <= w_wait_high_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt + CNT_W'(1);
    w_bit_idx_next   = r_bit_idx;
    w_shift_next     = r_shift;
    w_outdata_next   = r_outdata;
    w_valid_next     = 1'b0;
    w_frame_err_next = 1'b0;
    w_wait_high_next = r_wait_high;

    case (r_state)
      ST_IDLE: begin
        w_cnt_next     = '0;
        w_bit_idx_next = '0;
        // After a framing error the line must go high before a new start is trusted.
        if (r_wait_high) begin
          if (w_rxd_s) w_wait_high_next = 1'b0;
        end else if (!w_rxd_s) begin
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        if (r_cnt == LP_HALF) begin
          w_cnt_next   = '0;
          w_state_next = w_rxd_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_cnt == LP_FULL) begin
          w_cnt_next              = '0;
          w_shift_next[r_bit_idx] = w_rxd_s;
          if (r_bit_idx == LP_LAST) begin
            w_bit_idx_next = '0;
            w_state_next   = ST_STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + IDX_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (r_cnt == LP_FULL) begin
          w_cnt_next   = '0;
          w_state_next = ST_IDLE;
          if (w_rxd_s) begin
            w_outdata_next = r_shift;
            w_valid_next   = 1'b1;
          end else begin
            w_frame_err_next = 1'b1;
            w_wait_high_next = 1'b1;
          end
        end
      end
      default: begin
        w_cnt_next   = '0;
        w_state_next = ST_IDLE;
      end
    endcase

    w_busy_next = (w_state_next != ST_IDLE);
  end

  assign outdata   = r_outdata;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at a scaled bit period of 48 clocks so the whole run stays
// short; every expected pulse is predicted from the frames the bench sends.
module tb_uart_rx;

  localparam int C      = 48;
  localparam int H      = C / 2;
  localparam int LAT    = 9 * C + H + 3;
  localparam int GAP    = 100;
  localparam int GLITCH = 20;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         t0;
  } ev_t;

  logic       clk_50M = 1'b0;
  logic       reset;
  logic       uart_rxd;
  logic [7:0] outdata;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_valid  = 0;
  int         n_ferr   = 0;
  int         cyc      = 0;
  logic [7:0] exp_out  = 8'h00;
  ev_t        evq[$];

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk_50M   (clk_50M),
    .reset     (reset),
    .uart_rxd  (uart_rxd),
    .outdata   (outdata),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk_50M = ~clk_50M;

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  // Model: each pulse must match the oldest outstanding frame, land LAT+-2
  // cycles after its start edge, and outdata must always be the last good byte.
  always @(posedge clk_50M) begin
    ev_t ev;
    #1;
    cyc++;
    if (reset) exp_out = 8'h00;
    chk_eq("valid and frame_err exclusive", 32'(valid & frame_err), 32'd0);
    if (valid || frame_err) begin
      chk_eq("pulse expected", 32'(evq.size() != 0), 32'd1);
      if (evq.size() != 0) begin
        ev = evq.pop_front();
        chk_eq("pulse kind frame_err", 32'(frame_err), 32'(ev.is_err));
        chk_rng("pulse latency", cyc - ev.t0, LAT - 2, LAT + 2);
        if (!ev.is_err) begin
          exp_out = ev.data;
          n_valid++;
        end else begin
          n_ferr++;
        end
      end
    end else if (evq.size() != 0 && cyc > evq[0].t0 + LAT + 2) begin
      chk_eq("pulse by deadline", 32'(valid | frame_err), 32'd1);
      void'(evq.pop_front());
    end
    chk_eq("outdata", 32'(outdata), 32'(exp_out));
  end

  task automatic idle(input int n);
    uart_rxd = 1'b1;
    repeat (n) @(negedge clk_50M);
  endtask

  // One frame with bit period per; rst_bit >= 0 pulses reset mid that data bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int per,
                            input bit expect_ev, input int rst_bit);
    ev_t ev;
    if (expect_ev) begin
      ev.is_err = !stop;
      ev.data   = d;
      ev.t0     = cyc;
      evq.push_back(ev);
    end
    uart_rxd = 1'b0;
    repeat (per) @(negedge clk_50M);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      if (i == rst_bit) begin
        repeat (per / 2) @(negedge clk_50M);
        reset = 1'b1;
        @(negedge clk_50M);
        reset = 1'b0;
        repeat (per - per / 2 - 1) @(negedge clk_50M);
      end else begin
        repeat (per) @(negedge clk_50M);
      end
    end
    uart_rxd = stop;
    repeat (per) @(negedge clk_50M);
  endtask

  initial begin
    int waited;
    reset    = 1'b1;
    uart_rxd = 1'b1;
    repeat (3) @(negedge clk_50M);
    reset = 1'b0;
    chk_eq("reset outdata", 32'(outdata), 32'h00);
    chk_eq("reset valid", 32'(valid), 32'd0);
    chk_eq("reset frame_err", 32'(frame_err), 32'd0);
    chk_eq("reset busy", 32'(busy), 32'd0);
    idle(20);

    // Three spaced frames.
    send_frame(8'h21, 1'b1, C, 1'b1, -1);
    idle(GAP);
    send_frame(8'h43, 1'b1, C, 1'b1, -1);
    idle(GAP);
    send_frame(8'h65, 1'b1, C, 1'b1, -1);
    idle(GAP);
    chk_eq("spaced frames last byte", 32'(outdata), 32'h65);
    chk_eq("spaced frames valid count", 32'(n_valid), 32'd3);
    chk_eq("spaced frames frame_err count", 32'(n_ferr), 32'd0);

    // Back-to-back frames.
    send_frame(8'h55, 1'b1, C, 1'b1, -1);
    send_frame(8'hAA, 1'b1, C, 1'b1, -1);
    idle(GAP);
    chk_eq("back-to-back last byte", 32'(outdata), 32'hAA);
    chk_eq("back-to-back valid count", 32'(n_valid), 32'd5);

    // Short low glitch on an idle line.
    uart_rxd = 1'b0;
    repeat (5) @(negedge clk_50M);
    chk_eq("glitch busy", 32'(busy), 32'd1);
    repeat (GLITCH - 5) @(negedge clk_50M);
    uart_rxd = 1'b1;
    waited = 0;
    while (busy && waited < H) begin
      @(negedge clk_50M);
      waited++;
    end
    chk_eq("glitch busy cleared", 32'(busy), 32'd0);
    idle(GAP);
    chk_eq("glitch valid count", 32'(n_valid), 32'd5);
    chk_eq("glitch frame_err count", 32'(n_ferr), 32'd0);

    // Bad stop bit, then the line held low for two more bit times.
    send_frame(8'h3C, 1'b0, C, 1'b1, -1);
    uart_rxd = 1'b0;
    repeat (2 * C) @(negedge clk_50M);
    idle(LAT + GAP);
    chk_eq("frame error count", 32'(n_ferr), 32'd1);
    chk_eq("frame error keeps outdata", 32'(outdata), 32'hAA);
    chk_eq("frame error no valid", 32'(n_valid), 32'd5);

    // Reset during data bit 4 of F0, then a good 0F.
    send_frame(8'hF0, 1'b1, C, 1'b0, 4);
    idle(GAP);
    chk_eq("aborted frame outdata", 32'(outdata), 32'h00);
    chk_eq("aborted frame valid count", 32'(n_valid), 32'd5);
    send_frame(8'h0F, 1'b1, C, 1'b1, -1);
    idle(GAP);
    chk_eq("after reset byte", 32'(outdata), 32'h0F);
    chk_eq("after reset valid count", 32'(n_valid), 32'd6);

    // Transmitter rate off by about 2% each way.
    send_frame(8'hA5, 1'b1, C + 1, 1'b1, -1);
    idle(GAP);
    chk_eq("slow baud byte", 32'(outdata), 32'hA5);
    send_frame(8'h5A, 1'b1, C - 1, 1'b1, -1);
    idle(GAP);
    chk_eq("fast baud byte", 32'(outdata), 32'h5A);
    send_frame(8'hA5, 1'b1, C - 1, 1'b1, -1);
    idle(GAP);
    chk_eq("fast baud A5 byte", 32'(outdata), 32'hA5);
    chk_eq("drift valid count", 32'(n_valid), 32'd9);

    chk_eq("no outstanding frames", 32'(evq.size()), 32'd0);
    chk_eq("total frame_err count", 32'(n_ferr), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
